// File: rtl/intra_sad_gen.sv
// intra_sad_gen: vertical/horizontal/DC intra prediction per macroblock with
// saturated signed residues and clamped per-mode SADs.
module intra_sad_gen #(
  parameter int MB_SIZE = 8,
  parameter int NUM_MODES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [12:0] mbnumber,
  input  logic [MB_SIZE-1:0][7:0] top,
  input  logic [MB_SIZE-1:0][7:0] left,
  input  logic top_avail,
  input  logic left_avail,
  input  logic pix_valid,
  input  logic [7:0] pix_in,
  output logic busy,
  output logic done,
  output logic [12:0] mbnumber_out,
  output logic [NUM_MODES-1:0][7:0] sads,
  output logic signed [NUM_MODES-1:0][MB_SIZE*MB_SIZE-1:0][7:0] allresidues
);
  localparam int LG = $clog2(MB_SIZE);
  localparam int NPIX = MB_SIZE * MB_SIZE;
  localparam int CW = 2 * LG;
  typedef enum logic [1:0] {IDLE, DCCALC, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [MB_SIZE-1:0][7:0] top_r, left_r;
  logic ta, la;
  logic [12:0] mb_r;
  logic [7:0] dc, dc_sum;
  logic [12:0] sum_t, sum_l;
  logic [CW-1:0] cnt;
  logic [LG-1:0] row, col;
  logic take, last;
  logic [NUM_MODES-1:0][13:0] acc, acc_nx;
  logic [NUM_MODES-1:0][7:0] pred, res, mag;
  logic [NUM_MODES-1:0][8:0] dif;
  logic [NUM_MODES-1:0][NPIX-1:0][7:0] res_buf, res_nx;
  assign row = cnt[CW-1:LG];
  assign col = cnt[LG-1:0];
  assign take = state == ACCUM && pix_valid;
  assign last = take && cnt == CW'(NPIX - 1);
  always_comb begin
    state_nx = state == IDLE   ? (start ? DCCALC : IDLE) :
               state == DCCALC ? ACCUM :
               state == ACCUM  ? (last ? DONE : ACCUM) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int k = 0; k < MB_SIZE; k++) begin
      sum_t = sum_t + 13'(top_r[k]);
      sum_l = sum_l + 13'(left_r[k]);
    end
    dc_sum = ta && la ? 8'((sum_t + sum_l + 13'(MB_SIZE)) >> (LG + 1)) :
             ta ? 8'((sum_t + 13'(MB_SIZE / 2)) >> LG) :
             la ? 8'((sum_l + 13'(MB_SIZE / 2)) >> LG) : 8'd128;
  end
  always_comb begin
    pred[0] = ta ? top_r[col] : 8'd128;
    pred[1] = la ? left_r[row] : 8'd128;
    pred[2] = dc;
    res_nx = res_buf;
    for (int m = 0; m < NUM_MODES; m++) begin
      dif[m] = {1'b0, pix_in} - {1'b0, pred[m]};
      // 9-bit value fits in 8 bits signed exactly when its top two bits agree
      res[m] = dif[m][8] == dif[m][7] ? dif[m][7:0] : dif[m][8] ? 8'h80 : 8'h7f;
      mag[m] = res[m][7] ? 8'(-res[m]) : res[m];
      // once past 255 the clamped SAD is settled; holding avoids 14-bit wrap at 16x16
      acc_nx[m] = |acc[m][13:8] ? acc[m] : acc[m] + 14'(mag[m]);
      res_nx[m][cnt] = res[m];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      top_r <= '0;
      left_r <= '0;
      ta <= 1'b0;
      la <= 1'b0;
      mb_r <= '0;
      dc <= '0;
      cnt <= '0;
      acc <= '0;
      res_buf <= '0;
      mbnumber_out <= '0;
      sads <= '0;
      allresidues <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        top_r <= top;
        left_r <= left;
        ta <= top_avail;
        la <= left_avail;
        mb_r <= mbnumber;
      end
      if (state == DCCALC) begin
        dc <= dc_sum;
        cnt <= '0;
        acc <= '0;
      end
      if (take) begin
        cnt <= cnt + CW'(1);
        acc <= acc_nx;
        res_buf <= res_nx;
      end
      if (last) begin
        mbnumber_out <= mb_r;
        allresidues <= res_nx;
        for (int m = 0; m < NUM_MODES; m++)
          sads[m] <= |acc_nx[m][13:8] ? 8'hff : acc_nx[m][7:0];
      end
    end
  end
endmodule

// File: tb/tb_intra_sad_gen.sv
// tb_intra_sad_gen: directed table plus randomized macroblocks against an arithmetic model.
module tb_intra_sad_gen;
  localparam int MB = 8;
  localparam int NP = MB * MB;
  logic clk = 1'b0;
  logic reset, start, top_avail, left_avail, pix_valid, busy, done;
  logic [12:0] mbnumber, mbnumber_out;
  logic [MB-1:0][7:0] top, left;
  logic [7:0] pix_in;
  logic [2:0][7:0] sads;
  logic [2:0][NP-1:0][7:0] allresidues;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] s_top[MB], s_left[MB], s_px[NP];
  bit s_ta, s_la;
  logic [12:0] s_mbn;
  int exp_sad[3];
  int exp_res[3][NP];
  logic [2:0][7:0] prev_sads;
  typedef struct {
    bit ta, la;
    int tv, lv, pv;
    int s0, s1, s2, r0;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  intra_sad_gen #(.MB_SIZE(MB), .NUM_MODES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .top(top), .left(left), .top_avail(top_avail), .left_avail(left_avail),
    .pix_valid(pix_valid), .pix_in(pix_in), .busy(busy), .done(done),
    .mbnumber_out(mbnumber_out), .sads(sads), .allresidues(allresidues)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model();
    int st, sl, dcv, pr, d, sum;
    st = 0;
    sl = 0;
    for (int k = 0; k < MB; k++) begin
      st += s_top[k];
      sl += s_left[k];
    end
    if (s_ta && s_la) dcv = (st + sl + MB) / (2 * MB);
    else if (s_ta) dcv = (st + MB / 2) / MB;
    else if (s_la) dcv = (sl + MB / 2) / MB;
    else dcv = 128;
    for (int m = 0; m < 3; m++) begin
      sum = 0;
      for (int i = 0; i < MB; i++)
        for (int j = 0; j < MB; j++) begin
          pr = m == 0 ? (s_ta ? int'(s_top[j]) : 128) : m == 1 ? (s_la ? int'(s_left[i]) : 128) : dcv;
          d = int'(s_px[i * MB + j]) - pr;
          d = d > 127 ? 127 : d < -128 ? -128 : d;
          exp_res[m][i * MB + j] = d;
          sum += d < 0 ? -d : d;
        end
      exp_sad[m] = sum > 255 ? 255 : sum;
    end
  endtask

  task automatic run_mb(input int gap, input bit poke);
    int t0, nbad;
    bit got, early;
    model();
    top_avail = s_ta;
    left_avail = s_la;
    mbnumber = s_mbn;
    for (int k = 0; k < MB; k++) begin
      top[k] = s_top[k];
      left[k] = s_left[k];
    end
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    top = {$urandom, $urandom};
    left = {$urandom, $urandom};
    mbnumber = 13'($urandom);
    top_avail = 1'($urandom);
    left_avail = 1'($urandom);
    @(posedge clk); #1;
    early = 1'b0;
    for (int p = 0; p < NP; p++) begin
      for (int g = 0; g < gap; g++) begin
        pix_valid = 1'b0;
        pix_in = 8'($urandom);
        start = poke && p == NP / 2;
        @(posedge clk); #1;
        if (done) early = 1'b1;
      end
      start = 1'b0;
      if (p == NP / 2) chk("hold_sads", int'(sads), int'(prev_sads));
      pix_valid = 1'b1;
      pix_in = s_px[p];
      @(posedge clk); #1;
      if (p < NP - 1 && done) early = 1'b1;
    end
    pix_valid = 1'b0;
    chk("early_done", int'(early), 0);
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++)
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    chk("done_seen", int'(got), 1);
    chk("latency", cyc - t0, 2 + (gap + 1) * NP);
    chk("busy_at_done", int'(busy), 1);
    chk("mbnumber_out", int'(mbnumber_out), int'(s_mbn));
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("sad%0d", m), int'(sads[m]), exp_sad[m]);
      nbad = 0;
      for (int k = 0; k < NP; k++)
        if ($signed(allresidues[m][k]) != exp_res[m][k]) nbad++;
      chk($sformatf("res%0d_bad_count", m), nbad, 0);
      prev_sads[m] = 8'(exp_sad[m]);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  task automatic gen_rand();
    int b, v;
    bit near;
    s_ta = 1'($urandom);
    s_la = 1'($urandom);
    s_mbn = 13'($urandom);
    near = 1'($urandom);
    b = $urandom_range(255);
    for (int k = 0; k < MB; k++) begin
      v = near ? b + $urandom_range(16) - 8 : $urandom_range(255);
      s_top[k] = 8'(v < 0 ? 0 : v > 255 ? 255 : v);
      v = near ? b + $urandom_range(16) - 8 : $urandom_range(255);
      s_left[k] = 8'(v < 0 ? 0 : v > 255 ? 255 : v);
    end
    for (int p = 0; p < NP; p++) begin
      v = near ? b + $urandom_range(6) - 3 : $urandom_range(255);
      s_px[p] = 8'(v < 0 ? 0 : v > 255 ? 255 : v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit bad;
    tbl[0] = '{0, 0, 90, 90, 130, 128, 128, 128, 2};
    tbl[1] = '{1, 0, 255, 77, 0, 255, 255, 255, -128};
    tbl[2] = '{1, 1, 100, 50, 76, 255, 255, 64, -24};
    tbl[3] = '{0, 1, 33, 129, 129, 64, 0, 0, 1};
    tbl[4] = '{1, 1, 127, 128, 128, 64, 0, 0, 1};
    tbl[5] = '{1, 0, 0, 200, 255, 255, 255, 255, 127};
    reset = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
    top = '0;
    left = '0;
    top_avail = 1'b0;
    left_avail = 1'b0;
    mbnumber = '0;
    prev_sads = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mbnumber_out", int'(mbnumber_out), 0);
    chk("rst_sads", int'(sads), 0);
    chk("rst_allresidues_zero", int'(allresidues == '0), 1);
    bad = 1'b0;
    repeat (6) begin
      pix_valid = 1'b1;
      pix_in = 8'($urandom);
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    pix_valid = 1'b0;
    chk("idle_pix_ignored", int'(bad), 0);

    for (int k = 0; k < MB; k++) begin
      s_top[k] = 8'(k * 10);
      s_left[k] = 8'($urandom);
    end
    for (int p = 0; p < NP; p++) s_px[p] = 8'((p % MB) * 10);
    s_ta = 1'b1;
    s_la = 1'b1;
    s_mbn = 13'd4321;
    run_mb(0, 1'b0);
    chk("ramp_sad0", int'(sads[0]), 0);
    chk("ramp_res0_zero", int'(allresidues[0] == '0), 1);

    for (int v = 0; v < 6; v++) begin
      s_ta = tbl[v].ta;
      s_la = tbl[v].la;
      for (int k = 0; k < MB; k++) begin
        s_top[k] = 8'(tbl[v].tv);
        s_left[k] = 8'(tbl[v].lv);
      end
      for (int p = 0; p < NP; p++) s_px[p] = 8'(tbl[v].pv);
      s_mbn = 13'($urandom);
      run_mb(0, 1'b0);
      chk($sformatf("vec%0d_sad0", v), int'(sads[0]), tbl[v].s0);
      chk($sformatf("vec%0d_sad1", v), int'(sads[1]), tbl[v].s1);
      chk($sformatf("vec%0d_sad2", v), int'(sads[2]), tbl[v].s2);
      chk($sformatf("vec%0d_res0_first", v), $signed(allresidues[0][0]), tbl[v].r0);
      chk($sformatf("vec%0d_res0_last", v), $signed(allresidues[0][NP-1]), tbl[v].r0);
    end

    gen_rand();
    run_mb(0, 1'b0);
    run_mb(1, 1'b1);

    gen_rand();
    mbnumber = s_mbn;
    top_avail = s_ta;
    left_avail = s_la;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    bad = 1'b0;
    for (int p = 0; p < 20; p++) begin
      pix_valid = 1'b1;
      pix_in = s_px[p];
      @(posedge clk); #1;
      if (done) bad = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pix_valid = 1'b0;
    if (done) bad = 1'b1;
    chk("abort_no_done", int'(bad), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sads", int'(sads), 0);
    chk("abort_mbnumber_out", int'(mbnumber_out), 0);
    chk("abort_allresidues_zero", int'(allresidues == '0), 1);
    prev_sads = '0;
    run_mb(0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      gen_rand();
      run_mb(r % 4 == 3 ? 1 : 0, 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
